// File: rtl/acq_capture_ctrl_if.sv
// Bus bundle between the ADC front-end / host control side and the capture controller.
// master drives control and ADC samples; slave is the controller, driving RAM writes and status.
interface acq_capture_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic              arm;
    logic              abort;
    logic [ADDR_W-1:0] pre_len;
    logic [ADDR_W:0]   post_len;
    logic              trig_in;
    logic              adc_valid;
    logic [DATA_W-1:0] adc_data;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [ADDR_W-1:0] trig_addr;
    logic              busy;
    logic              done;
    logic              timed_out;

    modport master (
        output arm, abort, pre_len, post_len, trig_in, adc_valid, adc_data,
        input  ram_we, ram_waddr, ram_wdata, trig_addr, busy, done, timed_out
    );

    modport slave (
        input  arm, abort, pre_len, post_len, trig_in, adc_valid, adc_data,
        output ram_we, ram_waddr, ram_wdata, trig_addr, busy, done, timed_out
    );
endinterface

// File: rtl/acq_capture_ctrl.sv
// Circular-buffer capture sequencer: pre-trigger history plus post-trigger samples into capture RAM.
// Optional auto-trigger timeout enabled by defining ACQ_TRIG_TIMEOUT_EN.
//
//   state       | meaning
//   S_IDLE      | no capture, waiting for arm
//   S_PRE       | filling pre-trigger history, trigger ignored
//   S_WAIT_TRIG | writing circularly until the first qualified trigger
//   S_POST      | writing the remaining post-trigger samples
//   S_DONE      | window complete, trig_addr valid
module acq_capture_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 65535
) (
    input logic               clk,
    input logic               rst,
    acq_capture_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WAIT_TRIG,
        S_POST,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};

    if (TIMEOUT_CYC < 1) begin : g_timeout_chk
        $error("TIMEOUT_CYC must be at least 1");
    end

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] pre_len_q, pre_len_d;
    logic [ADDR_W:0]   eff_post_q, eff_post_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic              timed_out_q, timed_out_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_waddr_q, ram_waddr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              busy_q, done_q;

    logic              active;
    logic              tmo_hit;
    logic [ADDR_W:0]   room;
    logic [ADDR_W:0]   post_min;
    logic [ADDR_W:0]   eff_post_arm;

    // eff_post = max(1, min(post_len, DEPTH - pre_len)) so the window never exceeds the RAM
    assign room         = DEPTH_L - {1'b0, bus.pre_len};
    assign post_min     = (bus.post_len < room) ? bus.post_len : room;
    assign eff_post_arm = (post_min == '0) ? (ADDR_W+1)'(1) : post_min;

    assign active = (state_q == S_PRE) || (state_q == S_WAIT_TRIG) || (state_q == S_POST);

`ifdef ACQ_TRIG_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic [TMO_W-1:0] tmo_q, tmo_d;

    assign tmo_hit = (tmo_q == '0);

    // Down-counter reloaded on every entry into S_WAIT_TRIG, parks at zero once expired
    always_comb begin
        tmo_d = tmo_q;
        if ((state_d == S_WAIT_TRIG) && (state_q != S_WAIT_TRIG)) begin
            tmo_d = TMO_W'(TIMEOUT_CYC);
        end else if ((state_q == S_WAIT_TRIG) && (tmo_q != '0)) begin
            tmo_d = tmo_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        pre_len_d   = pre_len_q;
        eff_post_d  = eff_post_q;
        cnt_d       = cnt_q;
        trig_addr_d = trig_addr_q;
        timed_out_d = timed_out_q;
        ram_we_d    = 1'b0;
        ram_waddr_d = ram_waddr_q;
        ram_wdata_d = ram_wdata_q;

        if (bus.abort) begin
            state_d = S_IDLE;
        end else if (bus.arm && ((state_q == S_IDLE) || (state_q == S_DONE))) begin
            pre_len_d   = bus.pre_len;
            eff_post_d  = eff_post_arm;
            cnt_d       = {1'b0, bus.pre_len};
            wptr_d      = '0;
            timed_out_d = 1'b0;
            state_d     = (bus.pre_len == '0) ? S_WAIT_TRIG : S_PRE;
        end else if (active && bus.adc_valid) begin
            ram_we_d    = 1'b1;
            ram_waddr_d = wptr_q;
            ram_wdata_d = bus.adc_data;
            wptr_d      = wptr_q + 1'b1;
            case (state_q)
                S_PRE: begin
                    if (cnt_q == (ADDR_W+1)'(1)) begin
                        state_d = S_WAIT_TRIG;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_WAIT_TRIG: begin
                    if (bus.trig_in || tmo_hit) begin
                        // The trigger sample itself is post sample #1
                        trig_addr_d = wptr_q - pre_len_q;
                        timed_out_d = tmo_hit && !bus.trig_in;
                        if (eff_post_q == (ADDR_W+1)'(1)) begin
                            state_d = S_DONE;
                        end else begin
                            cnt_d   = eff_post_q - 1'b1;
                            state_d = S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (cnt_q == (ADDR_W+1)'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wptr_q      <= '0;
            pre_len_q   <= '0;
            eff_post_q  <= '0;
            cnt_q       <= '0;
            trig_addr_q <= '0;
            timed_out_q <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_waddr_q <= '0;
            ram_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            pre_len_q   <= pre_len_d;
            eff_post_q  <= eff_post_d;
            cnt_q       <= cnt_d;
            trig_addr_q <= trig_addr_d;
            timed_out_q <= timed_out_d;
            ram_we_q    <= ram_we_d;
            ram_waddr_q <= ram_waddr_d;
            ram_wdata_q <= ram_wdata_d;
            busy_q      <= (state_d == S_PRE) || (state_d == S_WAIT_TRIG) || (state_d == S_POST);
            done_q      <= (state_d == S_DONE);
        end
    end

    assign bus.ram_we    = ram_we_q;
    assign bus.ram_waddr = ram_waddr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.trig_addr = trig_addr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.timed_out = timed_out_q;

endmodule

// File: tb/tb_acq_capture_ctrl.sv
// Directed bench for acq_capture_ctrl with a 16-entry capture RAM (ADDR_W=4).
// Expected values are hand-derived from the capture window rules.
module tb_acq_capture_ctrl;

    localparam int DW = 16;
    localparam int AW = 4;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   wr_total = 0;
    int   base;
    logic [AW-1:0] wr_addr [0:255];

    acq_capture_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    acq_capture_ctrl #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .TIMEOUT_CYC(50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every RAM write the controller issues
    always @(posedge clk) begin
        if (bus.ram_we === 1'b1) begin
            wr_addr[wr_total % 256] = bus.ram_waddr;
            wr_total = wr_total + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic t, input logic [DW-1:0] d);
        bus.adc_valid = v;
        bus.trig_in   = t;
        bus.adc_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input logic [AW-1:0] pre, input logic [AW:0] post);
        bus.arm       = 1'b1;
        bus.pre_len   = pre;
        bus.post_len  = post;
        bus.adc_valid = 1'b0;
        bus.trig_in   = 1'b0;
        @(posedge clk);
        #1;
        bus.arm = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.arm       = 1'b0;
        bus.abort     = 1'b0;
        bus.pre_len   = '0;
        bus.post_len  = '0;
        bus.trig_in   = 1'b0;
        bus.adc_valid = 1'b0;
        bus.adc_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ram_we", 32'(bus.ram_we), 0);
        chk("rst_waddr", 32'(bus.ram_waddr), 0);
        chk("rst_wdata", 32'(bus.ram_wdata), 0);
        chk("rst_trig_addr", 32'(bus.trig_addr), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_timed_out", 32'(bus.timed_out), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Case 1: pre 4, post 4, trigger on sample 9 -> window starts at 5, samples 0..12 written
        do_arm(4'd4, 5'd4);
        chk("t1_busy_after_arm", 32'(bus.busy), 1);
        base = wr_total;
        for (int i = 0; i < 13; i++) begin
            step(1'b1, (i == 9), DW'(16'h0100 + i));
            if (i == 11) chk("t1_done_early", 32'(bus.done), 0);
        end
        chk("t1_done", 32'(bus.done), 1);
        chk("t1_busy", 32'(bus.busy), 0);
        chk("t1_trig_addr", 32'(bus.trig_addr), 5);
        chk("t1_last_we", 32'(bus.ram_we), 1);
        chk("t1_last_waddr", 32'(bus.ram_waddr), 12);
        chk("t1_last_wdata", 32'(bus.ram_wdata), 32'h010C);
        step(1'b1, 1'b0, 16'hBEEF);
        chk("t1_no_write_in_done", 32'(bus.ram_we), 0);
        chk("t1_write_count", 32'(wr_total - base), 13);
        chk("t1_first_addr", 32'(wr_addr[base % 256]), 0);
        chk("t1_trig_sample_addr", 32'(wr_addr[(base + 9) % 256]), 9);

        // Case 2: trig during PRE ignored, trigger on sample 20 -> wptr 4, trig_addr 1, wraps
        do_arm(4'd3, 5'd4);
        for (int i = 0; i < 24; i++) begin
            step(1'b1, (i < 3) || (i == 20), DW'(16'h0200 + i));
            if (i == 2) chk("t2_pre_trig_ignored", 32'(bus.busy), 1);
            if (i == 22) chk("t2_done_early", 32'(bus.done), 0);
        end
        chk("t2_done", 32'(bus.done), 1);
        chk("t2_trig_addr", 32'(bus.trig_addr), 1);
        chk("t2_wrapped_waddr", 32'(bus.ram_waddr), 7);

        // Case 3a: pre 10, post 12 -> eff_post 6, trigger at sample 10, last sample 15
        do_arm(4'd10, 5'd12);
        base = wr_total;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, (i >= 10), DW'(16'h0300 + i));
            if (i == 14) chk("t3a_done_early", 32'(bus.done), 0);
        end
        chk("t3a_done", 32'(bus.done), 1);
        chk("t3a_trig_addr", 32'(bus.trig_addr), 0);
        chk("t3a_waddr", 32'(bus.ram_waddr), 15);
        step(1'b0, 1'b0, 16'h0);
        chk("t3a_write_count", 32'(wr_total - base), 16);

        // Case 3b: pre 0, post 0 -> straight to WAIT_TRIG, trigger sample only
        do_arm(4'd0, 5'd0);
        chk("t3b_busy", 32'(bus.busy), 1);
        step(1'b1, 1'b0, 16'h0400);
        chk("t3b_done_early", 32'(bus.done), 0);
        step(1'b1, 1'b1, 16'h0401);
        chk("t3b_done", 32'(bus.done), 1);
        chk("t3b_trig_addr", 32'(bus.trig_addr), 1);
        chk("t3b_waddr", 32'(bus.ram_waddr), 1);

        // Case 4: abort in POST with a valid sample, then arm+abort together
        do_arm(4'd2, 5'd8);
        step(1'b1, 1'b0, 16'h0500);
        step(1'b1, 1'b0, 16'h0501);
        step(1'b1, 1'b1, 16'h0502);
        step(1'b1, 1'b0, 16'h0503);
        chk("t4_pre_abort_we", 32'(bus.ram_we), 1);
        chk("t4_pre_abort_waddr", 32'(bus.ram_waddr), 3);
        bus.abort = 1'b1;
        step(1'b1, 1'b0, 16'h0504);
        bus.abort = 1'b0;
        chk("t4_abort_no_write", 32'(bus.ram_we), 0);
        chk("t4_abort_busy", 32'(bus.busy), 0);
        chk("t4_abort_done", 32'(bus.done), 0);
        chk("t4_abort_trig_addr_kept", 32'(bus.trig_addr), 0);
        step(1'b1, 1'b1, 16'h0505);
        chk("t4_idle_no_write", 32'(bus.ram_we), 0);
        bus.arm   = 1'b1;
        bus.abort = 1'b1;
        step(1'b1, 1'b0, 16'h0506);
        bus.arm   = 1'b0;
        bus.abort = 1'b0;
        chk("t4_arm_abort_busy", 32'(bus.busy), 0);
        step(1'b1, 1'b1, 16'h0507);
        chk("t4_arm_abort_no_write", 32'(bus.ram_we), 0);
        chk("t4_arm_abort_done", 32'(bus.done), 0);

        // Case 5: valid toggling, trig held high in gaps, arm while busy ignored -> same window as case 1
        do_arm(4'd4, 5'd4);
        base = wr_total;
        for (int i = 0; i < 13; i++) begin
            step(1'b1, (i == 9), DW'(16'h0600 + i));
            if (i == 11) chk("t5_done_early", 32'(bus.done), 0);
            if (i < 12) begin
                if (i == 6) begin
                    bus.arm     = 1'b1;
                    bus.pre_len = 4'd0;
                end
                step(1'b0, 1'b1, 16'hDEAD);
                bus.arm = 1'b0;
            end
        end
        chk("t5_done", 32'(bus.done), 1);
        chk("t5_trig_addr", 32'(bus.trig_addr), 5);
        chk("t5_waddr", 32'(bus.ram_waddr), 12);
        chk("t5_wdata", 32'(bus.ram_wdata), 32'h060C);
        step(1'b0, 1'b0, 16'h0);
        chk("t5_write_count", 32'(wr_total - base), 13);

        // Case 6: no trigger in WAIT_TRIG for 70 valid samples
        do_arm(4'd1, 5'd2);
        step(1'b1, 1'b0, 16'h0700);
        for (int i = 0; i < 70; i++) begin
            step(1'b1, 1'b0, DW'(16'h0701 + i));
        end
`ifdef ACQ_TRIG_TIMEOUT_EN
        chk("t6_auto_done", 32'(bus.done), 1);
        chk("t6_timed_out", 32'(bus.timed_out), 1);
        chk("t6_busy", 32'(bus.busy), 0);
`else
        chk("t6_no_done", 32'(bus.done), 0);
        chk("t6_still_busy", 32'(bus.busy), 1);
        chk("t6_timed_out_zero", 32'(bus.timed_out), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
